mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch stage (read-only) and the memory stage (load/store).
- Sits between the fetch/memory stage interfaces and the single memory model.
- Sequences exactly one outstanding transaction at a time.
- Data accesses have fixed priority, bounded by a fetch anti-starvation counter.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 wide)
STARVE_LIMIT, 4, number of consecutive arbitration losses by fetch before fetch is forced to win (must be >= 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted by memory
if_rvalid  out  1  fetch read data valid (one cycle)
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data request; held with its fields until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_be  in  DATA_W/8  store byte enables
dm_gnt  out  1  data request accepted
dm_rvalid  out  1  load data valid or store acknowledge (one cycle)
dm_rdata  out  DATA_W  load data
mem_req  out  1  request to memory
mem_we  out  1  write enable to memory
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_be  out  DATA_W/8  byte enables to memory (all ones for fetch)
mem_gnt  in  1  memory accepts mem_req this cycle
mem_rvalid  in  1  memory response valid; asserted for both reads and writes
mem_rdata  in  DATA_W  memory read data
starve_cnt  out  $clog2(STARVE_LIMIT+1)  current fetch-loss count (debug)
err_spurious  out  1  one-cycle pulse when mem_rvalid arrives with no transaction outstanding

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All outputs are 0; rdata outputs are 0.
  - Reset mid-transaction abandons it: a late mem_rvalid after reset flags err_spurious and is not forwarded.
- States:
  - IDLE: no transaction.
  - REQ: owner locked, mem_req asserted, waiting for mem_gnt.
  - WAIT: granted, waiting for mem_rvalid.
- IDLE arbitration (combinational, same cycle):
  - Winner is DM if dm_req and not (if_req and starve_cnt==STARVE_LIMIT).
  - Otherwise the winner is IF if if_req; otherwise none.
  - With a winner: mem_req=1 and mem_* carry the winner's fields (fetch: we=0, be=all ones, wdata=0).
  - mem_gnt=1 that cycle: the winner's gnt=1 combinationally, and the next state is WAIT with owner=winner.
  - mem_gnt=0 that cycle: next state is REQ with owner=winner.
- REQ:
  - mem_req=1 with the locked owner's fields; no re-arbitration, even if a higher-priority request appears.
  - On mem_gnt, the owner's gnt pulses and the next state is WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: owner's rvalid=1 and owner's rdata=mem_rdata in the same cycle (combinational route), next state IDLE.
  - The other requester's rvalid stays 0 and its rdata holds 0.
- Throughput: at most one new grant every 2 cycles. IDLE is always visited after a response, so there is a one-cycle minimum bubble between transactions.
- Starvation counter (updated only on cycles that leave IDLE with a winner):
  - DM wins while if_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - IF wins: starve_cnt is cleared.
  - if_req=0 in IDLE: starve_cnt is cleared.
- Simultaneous events:
  - mem_gnt and mem_rvalid in the same cycle in REQ: mem_rvalid is spurious (flag it) and the grant is honoured.
  - Requesters deasserting req before gnt is a protocol violation; behaviour is undefined and not checked.
- err_spurious pulses for mem_rvalid in IDLE or REQ. The data is dropped and the state is unchanged.
- A requester's gnt is never asserted without mem_gnt. Both gnts are never asserted together, and both rvalids are never asserted together.

Test Plan:
- Reset then idle: no reqs for 5 cycles -> all outputs 0, state IDLE, starve_cnt=0.
- Lone fetch, if_addr=0x1000, mem_gnt=1 immediately, mem_rvalid 2 cycles later with rdata=0x003100B3 -> if_gnt in cycle 0, if_rvalid and if_rdata=0x003100B3 in cycle 2, dm outputs stay 0.
- Simultaneous dm store (addr=0x2004, wdata=0xA, be=0xF) and fetch (0x1004) -> DM wins first (mem_we=1, mem_be=0xF, dm_gnt), dm_rvalid ack, then the next IDLE grants IF, starve_cnt goes 1 then 0.
- Starvation: dm_req and if_req held continuously, STARVE_LIMIT=4 -> DM granted 4 times with starve_cnt 1..4, 5th grant goes to IF, starve_cnt then 0.
- Grant lock: IF wins with mem_gnt=0 for 3 cycles, dm_req rises in cycle 1 -> mem_addr stays if_addr, IF is granted when mem_gnt=1, DM is served after.
- Reset in WAIT: assert rst_n=0 mid-cycle -> outputs 0 immediately; after release, mem_rvalid=1 in IDLE -> err_spurious pulse, no rvalid to either requester.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the data stage.
// One transaction outstanding at a time; data wins unless fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               if_req,
  input  logic [ADDR_W-1:0]                  if_addr,
  output logic                               if_gnt,
  output logic                               if_rvalid,
  output logic [DATA_W-1:0]                  if_rdata,
  input  logic                               dm_req,
  input  logic                               dm_we,
  input  logic [ADDR_W-1:0]                  dm_addr,
  input  logic [DATA_W-1:0]                  dm_wdata,
  input  logic [DATA_W/8-1:0]                dm_be,
  output logic                               dm_gnt,
  output logic                               dm_rvalid,
  output logic [DATA_W-1:0]                  dm_rdata,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  output logic [DATA_W/8-1:0]                mem_be,
  input  logic                               mem_gnt,
  input  logic                               mem_rvalid,
  input  logic [DATA_W-1:0]                  mem_rdata,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]  starve_cnt,
  output logic                               err_spurious
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [1:0]       sel;
  logic             gnt_hit;
  logic             rsp_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign starve_cnt = starve_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    sel          = OWN_NONE;
    gnt_hit      = 1'b0;
    rsp_hit      = 1'b0;
    mem_req      = 1'b0;
    err_spurious = 1'b0;

    case (state_q)
      ST_IDLE: begin
        err_spurious = mem_rvalid;
        if (dm_req && !(if_req && starve_q == CNT_MAX)) sel = OWN_DM;
        else if (if_req)                                 sel = OWN_IF;
        if (sel != OWN_NONE) begin
          mem_req  = 1'b1;
          gnt_hit  = mem_gnt;
          owner_d  = sel;
          state_d  = mem_gnt ? ST_WAIT : ST_REQ;
          // Only a data win over a waiting fetch counts as a fetch loss.
          starve_d = (sel == OWN_DM && if_req) ? sat_inc(starve_q) : '0;
        end
      end
      ST_REQ: begin
        // Owner is locked; a late response here is stale and gets flagged.
        err_spurious = mem_rvalid;
        sel          = owner_q;
        mem_req      = 1'b1;
        gnt_hit      = mem_gnt;
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        sel     = owner_q;
        rsp_hit = mem_rvalid;
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_req && sel == OWN_DM) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end else if (mem_req && sel == OWN_IF) begin
      mem_addr  = if_addr;
      mem_be    = {BE_W{1'b1}};
    end

    if_gnt    = gnt_hit && sel == OWN_IF;
    dm_gnt    = gnt_hit && sel == OWN_DM;
    if_rvalid = rsp_hit && sel == OWN_IF;
    dm_rvalid = rsp_hit && sel == OWN_DM;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;

    // Outputs are held quiet for the whole time reset is asserted, even mid-cycle.
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_be       = '0;
      if_gnt       = 1'b0;
      dm_gnt       = 1'b0;
      if_rvalid    = 1'b0;
      dm_rvalid    = 1'b0;
      if_rdata     = '0;
      dm_rdata     = '0;
      err_spurious = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, starvation bound, grant lock, reset and spurious responses.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [2:0]  starve_cnt;
  logic        err_spurious;

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .starve_cnt(starve_cnt), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Packed status: {if_gnt,if_rvalid,dm_gnt,dm_rvalid,mem_req,mem_we,err_spurious}
  function automatic logic [31:0] flags();
    return {25'd0, if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, err_spurious};
  endfunction

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset and idle
    next_cyc(); next_cyc();
    #1 chk("reset_flags", flags(), 32'h0);
    chk("reset_starve", {29'd0, starve_cnt}, 32'd0);
    next_cyc(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      #1 chk("idle_flags", flags(), 32'h0);
      chk("idle_addr", mem_addr, 32'h0);
      chk("idle_starve", {29'd0, starve_cnt}, 32'd0);
    end

    // Lone fetch, immediate grant, response two cycles later
    next_cyc(); if_req = 1'b1; if_addr = 32'h1000; mem_gnt = 1'b1;
    #1 chk("f_flags", flags(), 32'b1000100);
    chk("f_addr", mem_addr, 32'h1000);
    chk("f_be", {28'd0, mem_be}, 32'hF);
    next_cyc(); if_req = 1'b0; mem_gnt = 1'b0;
    #1 chk("f_wait_flags", flags(), 32'h0);
    next_cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h003100B3;
    #1 chk("f_rsp_flags", flags(), 32'b0100000);
    chk("f_rdata", if_rdata, 32'h003100B3);
    chk("f_dm_rdata", dm_rdata, 32'h0);
    next_cyc(); mem_rvalid = 1'b0;
    #1 chk("f_after_flags", flags(), 32'h0);
    chk("f_after_rdata", if_rdata, 32'h0);

    // Simultaneous store and fetch: data first, then fetch
    next_cyc();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hA; dm_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h1004; mem_gnt = 1'b1;
    #1 chk("s_flags", flags(), 32'b0010110);
    chk("s_addr", mem_addr, 32'h2004);
    chk("s_wdata", mem_wdata, 32'hA);
    chk("s_be", {28'd0, mem_be}, 32'hF);
    next_cyc(); dm_req = 1'b0; dm_we = 1'b0; mem_gnt = 1'b0;
    #1 chk("s_starve1", {29'd0, starve_cnt}, 32'd1);
    next_cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h0;
    #1 chk("s_ack_flags", flags(), 32'b0001000);
    next_cyc(); mem_rvalid = 1'b0; mem_gnt = 1'b1;
    #1 chk("s_if_flags", flags(), 32'b1000100);
    chk("s_if_addr", mem_addr, 32'h1004);
    next_cyc(); if_req = 1'b0; mem_gnt = 1'b0;
    #1 chk("s_starve0", {29'd0, starve_cnt}, 32'd0);
    next_cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    #1 chk("s_if_rsp", flags(), 32'b0100000);
    chk("s_if_rdata", if_rdata, 32'h12345678);
    next_cyc(); mem_rvalid = 1'b0;

    // Starvation bound with both requests held
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; if_req = 1'b1; if_addr = 32'h1008;
    for (int g = 0; g < 5; g++) begin
      next_cyc(); mem_gnt = 1'b1; mem_rvalid = 1'b0;
      #1 chk("st_grant", flags(), (g < 4) ? 32'b0010100 : 32'b1000100);
      chk("st_addr", mem_addr, (g < 4) ? 32'h3000 : 32'h1008);
      next_cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
      #1 chk("st_cnt", {29'd0, starve_cnt}, (g < 4) ? 32'(g + 1) : 32'd0);
      chk("st_rsp", flags(), (g < 4) ? 32'b0001000 : 32'b0100000);
    end
    next_cyc(); mem_rvalid = 1'b0; dm_req = 1'b0; if_req = 1'b0;

    // Grant lock: fetch owns the port while data request appears
    next_cyc(); if_req = 1'b1; if_addr = 32'h3000;
    #1 chk("lk_req", flags(), 32'b0000100);
    chk("lk_addr0", mem_addr, 32'h3000);
    next_cyc(); dm_req = 1'b1; dm_addr = 32'h4000;
    #1 chk("lk_hold1", flags(), 32'b0000100);
    chk("lk_addr1", mem_addr, 32'h3000);
    next_cyc();
    #1 chk("lk_addr2", mem_addr, 32'h3000);
    next_cyc(); mem_gnt = 1'b1;
    #1 chk("lk_gnt", flags(), 32'b1000100);
    next_cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    #1 chk("lk_if_rsp", flags(), 32'b0100000);
    chk("lk_if_rdata", if_rdata, 32'hCAFE);
    next_cyc(); mem_rvalid = 1'b0; mem_gnt = 1'b1;
    #1 chk("lk_dm_gnt", flags(), 32'b0010100);
    chk("lk_dm_addr", mem_addr, 32'h4000);
    next_cyc(); dm_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
    #1 chk("lk_dm_rsp", flags(), 32'b0001000);
    chk("lk_dm_rdata", dm_rdata, 32'hBEEF);
    chk("lk_if_quiet", if_rdata, 32'h0);
    next_cyc(); mem_rvalid = 1'b0;

    // Response arriving together with the grant in REQ is stale
    next_cyc(); if_req = 1'b1; if_addr = 32'h5000;
    next_cyc(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1 chk("sp_req_flags", flags(), 32'b1000101);
    next_cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h88;
    #1 chk("sp_wait_rsp", flags(), 32'b0100000);
    chk("sp_rdata", if_rdata, 32'h88);
    next_cyc(); mem_rvalid = 1'b0;

    // Reset while waiting for a response
    next_cyc(); if_req = 1'b1; if_addr = 32'h6000; mem_gnt = 1'b1;
    next_cyc(); if_req = 1'b0; mem_gnt = 1'b0; dm_req = 1'b1; dm_addr = 32'h7000;
    #2 rst_n = 1'b0;
    #1 chk("rw_flags", flags(), 32'h0);
    chk("rw_addr", mem_addr, 32'h0);
    next_cyc(); dm_req = 1'b0;
    next_cyc(); rst_n = 1'b1;
    next_cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    #1 chk("rw_spurious", flags(), 32'b0000001);
    chk("rw_if_rdata", if_rdata, 32'h0);
    chk("rw_dm_rdata", dm_rdata, 32'h0);
    next_cyc(); mem_rvalid = 1'b0;
    #1 chk("rw_after", flags(), 32'h0);
    chk("rw_starve", {29'd0, starve_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
